// File: rtl/fft_mult_arbiter_if.sv
// Bundle of the two requester ports, the shared multiplier port and the
// status outputs of fft_mult_arbiter. The slave modport is the arbiter side.
interface fft_mult_arbiter_if #(
  parameter int DATA_W    = 48,
  parameter int TAG_DEPTH = 4
);
  localparam int CNT_W = $clog2(TAG_DEPTH) + 1;

  logic [DATA_W-1:0] i_req0_data;
  logic [DATA_W-1:0] i_req1_data;
  logic              i_req0_valid;
  logic              i_req1_valid;
  logic              o_req0_ready;
  logic              o_req1_ready;

  logic [DATA_W-1:0] o_mul_data;
  logic              o_mul_valid;
  logic              i_mul_ready;
  logic [DATA_W-1:0] i_mul_res;
  logic              i_mul_res_valid;
  logic              o_mul_res_ready;

  logic [DATA_W-1:0] o_rsp0_data;
  logic [DATA_W-1:0] o_rsp1_data;
  logic              o_rsp0_valid;
  logic              o_rsp1_valid;
  logic              i_rsp0_ready;
  logic              i_rsp1_ready;

  logic [CNT_W-1:0]  o_outstanding;
  logic              o_err_orphan;

  modport slave (
    input  i_req0_data, i_req1_data, i_req0_valid, i_req1_valid,
    output o_req0_ready, o_req1_ready,
    output o_mul_data, o_mul_valid,
    input  i_mul_ready, i_mul_res, i_mul_res_valid,
    output o_mul_res_ready,
    output o_rsp0_data, o_rsp1_data, o_rsp0_valid, o_rsp1_valid,
    input  i_rsp0_ready, i_rsp1_ready,
    output o_outstanding, o_err_orphan
  );

  modport master (
    output i_req0_data, i_req1_data, i_req0_valid, i_req1_valid,
    input  o_req0_ready, o_req1_ready,
    input  o_mul_data, o_mul_valid,
    output i_mul_ready, i_mul_res, i_mul_res_valid,
    input  o_mul_res_ready,
    input  o_rsp0_data, o_rsp1_data, o_rsp0_valid, o_rsp1_valid,
    output i_rsp0_ready, i_rsp1_ready,
    input  o_outstanding, o_err_orphan
  );
endinterface

// File: rtl/fft_mult_arbiter.sv
// Two-requester round-robin front end for a shared in-order multiplier.
// Granted words go through a single issue register; the requester ID of each
// issued word is queued in a tag FIFO so results can be routed back in order.
module fft_mult_arbiter #(
  parameter int DATA_W    = 48,
  parameter int TAG_DEPTH = 4
) (
  input logic               i_clk,
  input logic               i_rst_n,
  fft_mult_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // issue register (stage p1) feeding the multiplier
  logic              mul_vld_p1;
  logic [DATA_W-1:0] mul_data_p1;

  // arbitration and tag FIFO state
  logic              last_gnt;
  logic              tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  tag_cnt;
  logic              err_orphan;

  logic slot_free;
  logic fifo_full;
  logic fifo_empty;
  logic can_grant;
  logic gnt0;
  logic gnt1;
  logic push;
  logic head_tag;
  logic res_ready;
  logic pop;
  logic orphan;
  logic rsp0_vld;
  logic rsp1_vld;

  // Grant decision: the requester not granted last wins a tie; nothing is
  // granted while reset is held, the slot is busy or every tag is in flight.
  always_comb begin
    slot_free = !mul_vld_p1 || bus.i_mul_ready;
    fifo_full = (tag_cnt == CNT_W'(TAG_DEPTH));
    can_grant = i_rst_n && slot_free && !fifo_full;
    gnt0      = can_grant && bus.i_req0_valid && (!bus.i_req1_valid || last_gnt);
    gnt1      = can_grant && bus.i_req1_valid && (!bus.i_req0_valid || !last_gnt);
    push      = gnt0 || gnt1;
  end

  // Result routing by head tag; with no tag queued the result is swallowed
  // and flagged as an orphan.
  always_comb begin
    fifo_empty = (tag_cnt == '0);
    head_tag   = tag_mem[rd_ptr];
    rsp0_vld   = i_rst_n && !fifo_empty && !head_tag && bus.i_mul_res_valid;
    rsp1_vld   = i_rst_n && !fifo_empty &&  head_tag && bus.i_mul_res_valid;
    res_ready  = i_rst_n && (fifo_empty || (head_tag ? bus.i_rsp1_ready : bus.i_rsp0_ready));
    pop        = bus.i_mul_res_valid && res_ready && !fifo_empty;
    orphan     = i_rst_n && bus.i_mul_res_valid && fifo_empty;
  end

  // ---- stage p0 -> p1: load the issue register with the granted word ----
  // Issue register: loads on grant, drains when the multiplier takes the word.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      mul_vld_p1  <= 1'b0;
      mul_data_p1 <= '0;
    end else if (push) begin
      mul_vld_p1  <= 1'b1;
      mul_data_p1 <= gnt1 ? bus.i_req1_data : bus.i_req0_data;
    end else if (slot_free) begin
      mul_vld_p1  <= 1'b0;
    end
  end

  // Tag storage: records which requester owns each issued word.
  always_ff @(posedge i_clk) begin
    if (push) begin
      tag_mem[wr_ptr] <= gnt1;
    end
  end

  // Control state: FIFO pointers and count, round-robin pointer, orphan flag.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      tag_cnt    <= '0;
      last_gnt   <= 1'b1;
      err_orphan <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        last_gnt <= gnt1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      tag_cnt <= tag_cnt + CNT_W'(push) - CNT_W'(pop);
      if (orphan) begin
        err_orphan <= 1'b1;
      end
    end
  end

  assign bus.o_req0_ready    = gnt0;
  assign bus.o_req1_ready    = gnt1;
  assign bus.o_mul_valid     = mul_vld_p1;
  assign bus.o_mul_data      = mul_data_p1;
  assign bus.o_mul_res_ready = res_ready;
  assign bus.o_rsp0_valid    = rsp0_vld;
  assign bus.o_rsp1_valid    = rsp1_vld;
  assign bus.o_rsp0_data     = bus.i_mul_res;
  assign bus.o_rsp1_data     = bus.i_mul_res;
  assign bus.o_outstanding   = tag_cnt;
  assign bus.o_err_orphan    = err_orphan;
endmodule
